operand_issue: RTL
==================

// Module: operand_issue
// PURPOSE
//  Operand-fetch/issue stage directly upstream of the 32-bit ALU (add op 3'b000, sub op 3'b001).
//  Holds the register file and a per-register pending scoreboard.
//  Accepts decoded instructions over valid/ready and reads rs1/rs2, or rs1/immediate.
//  Presents registered operand1/operand2/operation to the ALU, and takes the ALU result back on a writeback port.
// PARAMETERS
//  DATA_W  32  operand/register width
//  NREG    8   number of registers; register 0 reads as zero
//  OP_W    3   ALU operation code width
// PORTS
//  clk          in   1                 single clock, rising edge
//  rst_n        in   1                 asynchronous, active-low reset
//  in_valid     in   1                 decoded instruction present
//  in_ready     out  1                 stage accepts instruction this cycle
//  in_op        in   OP_W              ALU operation
//  in_rs1       in   $clog2(NREG)      source register 1
//  in_rs2       in   $clog2(NREG)      source register 2 (ignored if in_use_imm)
//  in_rd        in   $clog2(NREG)      destination register
//  in_use_imm   in   1                 operand2 <- in_imm instead of reg[rs2]
//  in_imm       in   DATA_W            immediate
//  out_valid    out  1                 operands valid toward ALU
//  out_ready    in   1                 ALU side consumes this cycle
//  operand1     out  DATA_W            to ALU
//  operand2     out  DATA_W            to ALU
//  operation    out  OP_W              to ALU
//  out_rd       out  $clog2(NREG)      destination carried alongside
//  wb_en        in   1                 writeback strobe
//  wb_rd        in   $clog2(NREG)      writeback register
//  wb_data      in   DATA_W            writeback value (ALU result)
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - All registers = 0; all pending bits = 0.
//   - out_valid = 0; operand1/operand2/operation/out_rd = 0.
//   - Applies immediately, including mid-operation; an in-flight instruction is dropped.
//  Hazard:
//   - hazard = (pend[rs1] & rs1!=0 & !(wb_en & wb_rd==rs1))
//     | (!in_use_imm & pend[rs2] & rs2!=0 & !(wb_en & wb_rd==rs2)).
//  Handshake:
//   - in_ready = (!out_valid | out_ready) & !hazard. This is combinational; it may depend on the in_* fields but never on in_valid.
//   - Accept = in_valid & in_ready. Operands are registered the same edge, so latency is 1 cycle: out_valid=1 on the next cycle.
//   - The output holds stable while out_valid & !out_ready.
//   - out_valid clears when out_ready=1 and nothing is accepted.
//   - Full throughput: 1 instruction/cycle when there is no hazard and out_ready=1.
//  Read:
//   - Register 0 returns 0.
//   - Write-to-read bypass: a read of X while wb_en & wb_rd==X & X!=0 returns wb_data.
//  Write:
//   - On wb_en, reg[wb_rd] <= wb_data, unless wb_rd==0 (write ignored).
//  Scoreboard:
//   - Accept sets pend[in_rd] (not for rd 0).
//   - wb_en clears pend[wb_rd].
//   - If both hit the same register on the same edge, set wins (a newer producer is outstanding).
//   - Pending never applies to register 0.
//  Arithmetic: none here; all widths pass through unchanged.
//  No FSM beyond the out_valid bit: EMPTY (out_valid=0) <-> FULL (out_valid=1).
//   - EMPTY->FULL on accept.
//   - FULL->FULL on accept with out_ready, or on stall.
//   - FULL->EMPTY on out_ready without accept.
// STRUCTURE
//  Shared package: ALU op codes (OP_ADD=3'b000, OP_SUB=3'b001), default widths, and the reg-index type.
//  Sub-module: regfile_2r1w (NREG x DATA_W, two combinational read ports with bypass, one sync write port, reg 0 = 0).
//  Scoreboard and output register stay in operand_issue.
// TESTING
//  1. Reset: rst_n=0 mid-stream -> out_valid=0 and all pend=0 asynchronously; reading r3 after release gives 0.
//  2. Writeback then issue: wb r1=5, r2=3; issue op=000 rs1=1 rs2=2 rd=4 -> next cycle operand1=5, operand2=3, operation=000, out_rd=4.
//  3. RAW stall: issue rd=4, then rs1=4 with no wb -> in_ready=0; wb_en r4=8 that cycle -> accepted via bypass, operand1=8.
//  4. Backpressure: out_ready=0 for 3 cycles -> outputs stable and in_ready=0; out_ready=1 -> next instruction issued the following cycle.
//  5. Register 0: wb r0=7 ignored; issue rs1=0 with in_use_imm=1 and imm=9 -> operand1=0, operand2=9, never stalls.
//  6. Same-edge set/clear: accept rd=2 while wb_rd=2 -> pend[2] stays 1; a following read of r2 stalls until the next wb of r2.

Source files
------------

// File: rtl/operand_issue_pkg.sv
// Shared definitions for the operand-fetch/issue slice: ALU op codes, default widths, register index type.
// Pure declarations; no logic, no timing.
package operand_issue_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int NREG_DEF   = 8;
  localparam int OP_W_DEF   = 3;
  localparam int IDX_W_DEF  = $clog2(NREG_DEF);

  localparam logic [OP_W_DEF-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W_DEF-1:0] OP_SUB = 3'b001;

  typedef logic [IDX_W_DEF-1:0] reg_idx_t;

endpackage

// File: rtl/operand_issue_regfile.sv
// 2-read/1-write register file: combinational reads with write-to-read bypass, register 0 hardwired to zero.
// Reads are zero-latency, writes land on the next rising edge; no backpressure.
module regfile_2r1w
  import operand_issue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [$clog2(NREG)-1:0] rd_addr_a,
  output logic [DATA_W-1:0]       rd_data_a,
  input  logic [$clog2(NREG)-1:0] rd_addr_b,
  output logic [DATA_W-1:0]       rd_data_b,
  input  logic                    wr_en,
  input  logic [$clog2(NREG)-1:0] wr_addr,
  input  logic [DATA_W-1:0]       wr_data
);

  localparam int IDX_W = $clog2(NREG);

  logic [DATA_W-1:0] regs [NREG];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != '0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // A read that coincides with a write of the same register sees the new value.
  function automatic logic [DATA_W-1:0] read_port(input logic [IDX_W-1:0] addr);
    logic [DATA_W-1:0] val;
    val = regs[addr];
    if (addr == '0) begin
      val = '0;
    end else if (wr_en && (wr_addr == addr)) begin
      val = wr_data;
    end
    return val;
  endfunction

  always_comb begin
    rd_data_a = read_port(rd_addr_a);
    rd_data_b = read_port(rd_addr_b);
  end

endmodule

// File: rtl/operand_issue.sv
// Operand fetch/issue ahead of the ALU: reads rs1/rs2 (or imm), tracks pending writers, registers operands; 1-cycle latency.
// Holds output while out_ready is low; in_ready drops on a stalled output or a RAW hazard not resolved by this cycle's writeback.
module operand_issue
  import operand_issue_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int OP_W   = OP_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [OP_W-1:0]         in_op,
  input  logic [$clog2(NREG)-1:0] in_rs1,
  input  logic [$clog2(NREG)-1:0] in_rs2,
  input  logic [$clog2(NREG)-1:0] in_rd,
  input  logic                    in_use_imm,
  input  logic [DATA_W-1:0]       in_imm,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W-1:0]       operand1,
  output logic [DATA_W-1:0]       operand2,
  output logic [OP_W-1:0]         operation,
  output logic [$clog2(NREG)-1:0] out_rd,
  input  logic                    wb_en,
  input  logic [$clog2(NREG)-1:0] wb_rd,
  input  logic [DATA_W-1:0]       wb_data
);

  localparam int IDX_W = $clog2(NREG);

  typedef struct packed {
    logic [OP_W-1:0]   op;
    logic [IDX_W-1:0]  rd;
    logic [DATA_W-1:0] opa;
    logic [DATA_W-1:0] opb;
  } issue_t;

  logic [DATA_W-1:0] rd_data_a;
  logic [DATA_W-1:0] rd_data_b;
  logic [NREG-1:0]   pend;
  logic              hazard_rs1;
  logic              hazard_rs2;
  logic              hazard;
  logic              accept;
  issue_t            out_q;
  issue_t            out_d;

  regfile_2r1w #(
    .DATA_W (DATA_W),
    .NREG   (NREG)
  ) u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (in_rs1),
    .rd_data_a (rd_data_a),
    .rd_addr_b (in_rs2),
    .rd_data_b (rd_data_b),
    .wr_en     (wb_en),
    .wr_addr   (wb_rd),
    .wr_data   (wb_data)
  );

  // A writeback landing this cycle resolves the dependency through the read bypass.
  always_comb begin
    hazard_rs1 = pend[in_rs1] && (in_rs1 != '0) && !(wb_en && (wb_rd == in_rs1));
    hazard_rs2 = !in_use_imm && pend[in_rs2] && (in_rs2 != '0)
                 && !(wb_en && (wb_rd == in_rs2));
    hazard     = hazard_rs1 || hazard_rs2;
    in_ready   = (!out_valid || out_ready) && !hazard;
    accept     = in_valid && in_ready;
  end

  always_comb begin
    out_d     = out_q;
    out_d.op  = in_op;
    out_d.rd  = in_rd;
    out_d.opa = rd_data_a;
    out_d.opb = in_use_imm ? in_imm : rd_data_b;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_q     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_q     <= out_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // Set after clear: a newly accepted producer of the same register stays outstanding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (accept && (in_rd == IDX_W'(i))) begin
          pend[i] <= 1'b1;
        end else if (wb_en && (wb_rd == IDX_W'(i))) begin
          pend[i] <= 1'b0;
        end
      end
      pend[0] <= 1'b0;
    end
  end

  assign operand1  = out_q.opa;
  assign operand2  = out_q.opb;
  assign operation = out_q.op;
  assign out_rd    = out_q.rd;

endmodule
